// File: rtl/pc_fetch_sequencer.sv
// PC owner and instruction-fetch sequencer for the single-issue LEGv8 core.
// Fetches from PC, hands the word to decode via valid/ready, then applies the next-PC rule.
module pc_fetch_sequencer #(
  parameter logic [63:0] RESET_PC    = 64'h0,
  parameter int unsigned ACK_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             CLK,
  input  logic             Reset_L,
  output logic             IMemReq,
  output logic [63:0]      IMemAddr,
  input  logic             IMemAck,
  input  logic [31:0]      IMemData,
  output logic             InstrValid,
  input  logic             InstrReady,
  output logic [31:0]      Instr,
  output logic [63:0]      InstrPC,
  input  logic             Branch,
  input  logic             ALUZero,
  input  logic             Uncondbranch,
  input  logic [63:0]      SignExtImm64,
  output logic             Fault,
  output logic [1:0]       FaultCause,
  output logic [63:0]      FaultPC,
  output logic [CNT_W-1:0] RetireCount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_VALID = 2'd2,
    ST_FAULT = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_MISALIGN = 2'b01,
    CAUSE_TIMEOUT  = 2'b10
  } cause_e;

  localparam int unsigned     TO_W     = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(ACK_TIMEOUT);
  localparam bit              TO_EN    = (ACK_TIMEOUT != 0);

  state_e           state_q, state_d;
  logic [63:0]      pc_q, pc_d;
  logic [31:0]      instr_q, instr_d;
  logic [63:0]      instr_pc_q, instr_pc_d;
  cause_e           cause_q, cause_d;
  logic [63:0]      fault_pc_q, fault_pc_d;
  logic [CNT_W-1:0] retire_q, retire_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;

  logic        taken;
  logic [63:0] target;
  logic [TO_W-1:0] to_cnt_inc;

  // Uncondbranch wins outright; a conditional branch needs the zero flag.
  assign taken      = Uncondbranch | (Branch & ALUZero);
  assign target     = instr_pc_q + (taken ? SignExtImm64 : 64'd4);
  assign to_cnt_inc = to_cnt_q + 1'b1;

  always_comb begin
    // NOTE: every signal gets its default before the case, so no path can leave one unassigned and infer a latch.
    state_d    = state_q;
    pc_d       = pc_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    cause_d    = cause_q;
    fault_pc_d = fault_pc_q;
    retire_d   = retire_q;
    to_cnt_d   = to_cnt_q;

    unique case (state_q)
      ST_IDLE: state_d = ST_REQ;

      ST_REQ: begin
        if (IMemAck) begin
          instr_d    = IMemData;
          instr_pc_d = pc_q;
          to_cnt_d   = '0;
          state_d    = ST_VALID;
        end else if (TO_EN) begin
          to_cnt_d = to_cnt_inc;
          if (to_cnt_inc == TO_LIMIT) begin
            cause_d    = CAUSE_TIMEOUT;
            fault_pc_d = pc_q;
            state_d    = ST_FAULT;
          end
        end
      end

      ST_VALID: begin
        if (InstrReady) begin
          // The consumed instruction retires even when its target faults.
          retire_d = retire_q + 1'b1;
          if (target[1:0] == 2'b00) begin
            pc_d    = target;
            state_d = ST_REQ;
          end else begin
            cause_d    = CAUSE_MISALIGN;
            fault_pc_d = target;
            state_d    = ST_FAULT;
          end
        end
      end

      ST_FAULT: state_d = ST_FAULT;

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (!Reset_L) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      instr_q    <= '0;
      instr_pc_q <= '0;
      cause_q    <= CAUSE_NONE;
      fault_pc_q <= '0;
      retire_q   <= '0;
      to_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      cause_q    <= cause_d;
      fault_pc_q <= fault_pc_d;
      retire_q   <= retire_d;
      to_cnt_q   <= to_cnt_d;
    end
  end

  assign IMemReq     = (state_q == ST_REQ);
  assign IMemAddr    = pc_q;
  assign InstrValid  = (state_q == ST_VALID);
  assign Instr       = instr_q;
  assign InstrPC     = instr_pc_q;
  assign Fault       = (state_q == ST_FAULT);
  assign FaultCause  = cause_q;
  assign FaultPC     = fault_pc_q;
  assign RetireCount = retire_q;

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Self-checking bench for pc_fetch_sequencer: directed sequences, a branch vector table,
// and randomized traffic compared every cycle against a transaction-level reference model.
module tb_pc_fetch_sequencer;

  localparam logic [63:0] RESET_PC = 64'h0;
  localparam int          ACK_TO   = 16;

  logic        clk = 1'b0;
  logic        rst_l, ack, ready, br, zero, unc;
  logic [31:0] data;
  logic [63:0] imm;

  logic        req, valid, fault;
  logic [63:0] addr, instr_pc, fault_pc;
  logic [31:0] instr, retire;
  logic [1:0]  cause;

  logic        rst0_l;
  logic        ack0 = 1'b0;
  logic        ready0 = 1'b0;
  logic        req0, valid0, fault0;
  logic [63:0] addr0, instr_pc0, fault_pc0;
  logic [31:0] instr0, retire0;
  logic [1:0]  cause0;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc0    = 0;

  always #5 clk = ~clk;

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(ACK_TO), .CNT_W(32)) dut (
    .CLK(clk), .Reset_L(rst_l), .IMemReq(req), .IMemAddr(addr), .IMemAck(ack), .IMemData(data),
    .InstrValid(valid), .InstrReady(ready), .Instr(instr), .InstrPC(instr_pc),
    .Branch(br), .ALUZero(zero), .Uncondbranch(unc), .SignExtImm64(imm),
    .Fault(fault), .FaultCause(cause), .FaultPC(fault_pc), .RetireCount(retire)
  );

  pc_fetch_sequencer #(.RESET_PC(RESET_PC), .ACK_TIMEOUT(0), .CNT_W(32)) dut0 (
    .CLK(clk), .Reset_L(rst0_l), .IMemReq(req0), .IMemAddr(addr0), .IMemAck(ack0), .IMemData(data),
    .InstrValid(valid0), .InstrReady(ready0), .Instr(instr0), .InstrPC(instr_pc0),
    .Branch(br), .ALUZero(zero), .Uncondbranch(unc), .SignExtImm64(imm),
    .Fault(fault0), .FaultCause(cause0), .FaultPC(fault_pc0), .RetireCount(retire0)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input int n);
    rst_l = 1'b0;
    repeat (n) tick();
    rst_l = 1'b1;
  endtask

  // ---------------- reference model ----------------
  // Inputs are captured at each rising edge, the model advances at the following falling edge.
  logic        s_rst_l, s_ack, s_ready, s_br, s_zero, s_unc;
  logic [31:0] s_data;
  logic [63:0] s_imm;

  always @(posedge clk) begin
    s_rst_l <= rst_l;
    s_ack   <= ack;
    s_data  <= data;
    s_ready <= ready;
    s_br    <= br;
    s_zero  <= zero;
    s_unc   <= unc;
    s_imm   <= imm;
    if (rst0_l) cyc0 <= cyc0 + 1;
  end

  bit          m_known = 1'b0;
  bit          m_fetching, m_presenting, m_faulted;
  logic [63:0] m_pc, m_instr_pc, m_fault_pc, m_target;
  logic [31:0] m_instr, m_retired;
  logic [1:0]  m_cause;
  int          m_wait;

  task automatic model_step();
    if (!s_rst_l) begin
      m_known = 1'b1;
      m_fetching = 1'b0; m_presenting = 1'b0; m_faulted = 1'b0;
      m_pc = RESET_PC; m_instr = '0; m_instr_pc = '0;
      m_cause = 2'b00; m_fault_pc = '0; m_retired = '0; m_wait = 0;
    end else if (m_known && !m_faulted) begin
      if (m_fetching) begin
        if (s_ack) begin
          m_instr = s_data; m_instr_pc = m_pc; m_wait = 0;
          m_fetching = 1'b0; m_presenting = 1'b1;
        end else begin
          m_wait++;
          if (ACK_TO != 0 && m_wait == ACK_TO) begin
            m_cause = 2'b10; m_fault_pc = m_pc;
            m_fetching = 1'b0; m_faulted = 1'b1;
          end
        end
      end else if (m_presenting) begin
        if (s_ready) begin
          m_target  = m_instr_pc + ((s_unc || (s_br && s_zero)) ? s_imm : 64'd4);
          m_retired = m_retired + 1;
          m_presenting = 1'b0;
          if (m_target % 4 == 0) begin
            m_pc = m_target; m_fetching = 1'b1;
          end else begin
            m_cause = 2'b01; m_fault_pc = m_target; m_faulted = 1'b1;
          end
        end
      end else begin
        m_fetching = 1'b1;
      end
    end
  endtask

  always @(negedge clk) begin
    model_step();
    if (m_known) begin
      check("m_req", {63'd0, req}, {63'd0, m_fetching});
      check("m_valid", {63'd0, valid}, {63'd0, m_presenting});
      check("m_fault", {63'd0, fault}, {63'd0, m_faulted});
      if (m_fetching || !(m_presenting || m_faulted)) check("m_addr", addr, m_pc);
      check("m_instr", {32'd0, instr}, {32'd0, m_instr});
      check("m_instr_pc", instr_pc, m_instr_pc);
      check("m_cause", {62'd0, cause}, {62'd0, m_cause});
      check("m_fault_pc", fault_pc, m_fault_pc);
      check("m_retire", {32'd0, retire}, {32'd0, m_retired});
    end
  end

  // ---------------- branch vector table ----------------
  typedef struct {
    logic [63:0] base;
    logic        br, zero, unc;
    logic [63:0] imm;
    logic [63:0] exp_addr;
    logic [1:0]  exp_cause;
  } vec_t;

  vec_t vecs[9];

  initial begin
    vecs[0] = '{64'h40,  1'b1, 1'b1, 1'b0, 64'h20,                  64'h60,                  2'b00};
    vecs[1] = '{64'h40,  1'b1, 1'b0, 1'b0, 64'h20,                  64'h44,                  2'b00};
    vecs[2] = '{64'h40,  1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 64'h38,                  2'b00};
    vecs[3] = '{64'h40,  1'b0, 1'b1, 1'b0, 64'h20,                  64'h44,                  2'b00};
    vecs[4] = '{64'h40,  1'b1, 1'b0, 1'b1, 64'h10,                  64'h50,                  2'b00};
    vecs[5] = '{64'h100, 1'b0, 1'b0, 1'b1, 64'h6,                   64'h106,                 2'b01};
    vecs[6] = '{64'h100, 1'b1, 1'b1, 1'b0, 64'h2,                   64'h102,                 2'b01};
    vecs[7] = '{64'h40,  1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFBC, 64'hFFFF_FFFF_FFFF_FFFC, 2'b00};
    vecs[8] = '{64'h40,  1'b1, 1'b0, 1'b0, 64'h3,                   64'h44,                  2'b00};
  end

  // ---------------- stimulus ----------------
  initial begin
    int fault_age;
    int s;
    rst_l = 1'b0; rst0_l = 1'b0;
    ack = 1'b0; ready = 1'b0; br = 1'b0; zero = 1'b0; unc = 1'b0;
    data = '0; imm = '0;

    // Sequential fetch with ack and ready always high.
    ack = 1'b1; ready = 1'b1;
    tick();
    rst_pulse(1);
    rst0_l = 1'b1;
    for (int k = 0; k < 4; k++) begin
      data = $urandom;
      tick();
      check("seq_req", {63'd0, req}, 64'd1);
      check("seq_addr", addr, 64'(4 * k));
      check("seq_retire", {32'd0, retire}, 64'(k));
      tick();
      check("seq_valid", {63'd0, valid}, 64'd1);
      check("seq_instr_pc", instr_pc, 64'(4 * k));
    end

    // Branch rule table: jump to base, then consume one instruction with the row's flags.
    foreach (vecs[i]) begin
      br = 1'b0; zero = 1'b0; unc = 1'b1; imm = vecs[i].base;
      ack = 1'b1; ready = 1'b1;
      rst_pulse(2);
      tick();
      tick();
      tick();
      check("vec_jump_addr", addr, vecs[i].base);
      br = vecs[i].br; zero = vecs[i].zero; unc = vecs[i].unc; imm = vecs[i].imm;
      data = $urandom;
      tick();
      check("vec_instr_pc", instr_pc, vecs[i].base);
      tick();
      check("vec_fault", {63'd0, fault}, {63'd0, (vecs[i].exp_cause != 2'b00)});
      check("vec_cause", {62'd0, cause}, {62'd0, vecs[i].exp_cause});
      check("vec_retire", {32'd0, retire}, 64'd2);
      if (vecs[i].exp_cause != 2'b00) begin
        check("vec_fault_pc", fault_pc, vecs[i].exp_addr);
        repeat (3) begin
          tick();
          check("vec_fault_req", {63'd0, req}, 64'd0);
          check("vec_fault_sticky", {63'd0, fault}, 64'd1);
        end
      end else begin
        check("vec_req", {63'd0, req}, 64'd1);
        check("vec_addr", addr, vecs[i].exp_addr);
      end
    end

    // Slow memory and slow decode: stable request and stable presented instruction.
    br = 1'b0; zero = 1'b0; unc = 1'b0; imm = '0;
    ack = 1'b0; ready = 1'b0;
    rst_pulse(2);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("slow_req", {63'd0, req}, 64'd1);
      check("slow_addr", addr, 64'd0);
    end
    ack = 1'b1; data = 32'hDEAD_BEEF;
    tick();
    ack = 1'b0; data = 32'h1234_5678;
    check("slow_valid", {63'd0, valid}, 64'd1);
    for (int j = 0; j < 2; j++) begin
      tick();
      check("slow_hold_valid", {63'd0, valid}, 64'd1);
      check("slow_hold_instr", {32'd0, instr}, 64'hDEAD_BEEF);
      check("slow_hold_pc", instr_pc, 64'd0);
      check("slow_no_retire", {32'd0, retire}, 64'd0);
    end
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("slow_next_addr", addr, 64'd4);
    check("slow_retire", {32'd0, retire}, 64'd1);
    tick();
    check("slow_one_retire", {32'd0, retire}, 64'd1);

    // Ack timeout on the third fetch (PC=0x8).
    ack = 1'b1; ready = 1'b1;
    rst_pulse(1);
    repeat (5) tick();
    check("to_addr", addr, 64'h8);
    ack = 1'b0;
    for (int i = 1; i < ACK_TO; i++) begin
      tick();
      check("to_waiting", {63'd0, fault}, 64'd0);
    end
    tick();
    check("to_fault", {63'd0, fault}, 64'd1);
    check("to_cause", {62'd0, cause}, 64'h2);
    check("to_fault_pc", fault_pc, 64'h8);
    check("to_req_low", {63'd0, req}, 64'd0);

    // Reset from FAULT, then from VALID with a nonzero retire count.
    rst_l = 1'b0;
    tick();
    check("rstf_fault", {63'd0, fault}, 64'd0);
    check("rstf_cause", {62'd0, cause}, 64'd0);
    check("rstf_addr", addr, RESET_PC);
    rst_l = 1'b1; ack = 1'b1; ready = 1'b1;
    repeat (3) tick();
    ready = 1'b0;
    tick();
    check("rstv_valid", {63'd0, valid}, 64'd1);
    check("rstv_retire", {32'd0, retire}, 64'd1);
    rst_l = 1'b0;
    tick();
    check("rstv_all_zero", {req, valid, fault, cause, retire, instr, instr_pc, fault_pc}, '0);
    check("rstv_addr", addr, RESET_PC);
    rst_l = 1'b1;
    tick();
    check("rstv_restart", addr, RESET_PC);

    // Randomized traffic; the reference model checks every cycle.
    fault_age = 0;
    for (int i = 0; i < 3000; i++) begin
      ack   = ($urandom % 4) != 0;
      if ((i % 500) >= 478) ack = 1'b0;
      ready = ($urandom % 3) != 0;
      data  = $urandom;
      br    = 1'($urandom);
      zero  = 1'($urandom);
      unc   = 1'($urandom);
      s     = (int'($urandom_range(0, 64)) - 32) * 4;
      if (($urandom % 24) == 0) s = s + int'($urandom_range(1, 3));
      imm   = {{32{s[31]}}, s};
      fault_age = m_faulted ? fault_age + 1 : 0;
      rst_l = !((($urandom % 300) == 0) || (fault_age > 4));
      tick();
    end
    rst_l = 1'b1;

    // ACK_TIMEOUT=0 instance has waited over 1000 cycles without an ack.
    while (cyc0 < 1005) tick();
    check("noto_fault", {63'd0, fault0}, 64'd0);
    check("noto_req", {63'd0, req0}, 64'd1);
    check("noto_addr", addr0, RESET_PC);
    check("noto_quiet", {valid0, cause0, retire0, instr0, instr_pc0, fault_pc0}, '0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
